// File: rtl/receptor_sonar_ascii.sv
// Receiver for the sonar's 7O1 ASCII link: deserializes characters and parses
// "aaa,ddd#" frames into packed BCD angle/distance words with pronto/erro strobes.
module receptor_sonar_ascii #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] angulo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CNT_W-1:0] CNT_FIM  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MEIO = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } rx_estado_t;

    typedef enum logic [3:0] {
        CENT_A    = 4'd0,
        DEZ_A     = 4'd1,
        UNI_A     = 4'd2,
        VIRGULA   = 4'd3,
        CENT_D    = 4'd4,
        DEZ_D     = 4'd5,
        UNI_D     = 4'd6,
        CERQUILHA = 4'd7
    } pa_estado_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic paridade_impar(input logic [6:0] dados, input logic par);
        return ^{dados, par};
    endfunction

    function automatic logic eh_digito(input logic [6:0] c);
        return (c >= 7'h30) && (c <= 7'h39);
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx;
    rx_estado_t       r_rx_estado;
    rx_estado_t       w_rx_prox;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_nbit;
    logic [6:0]       r_dados;
    logic             r_par;
    logic             w_cnt_fim;
    logic             w_cnt_meio;
    logic             w_char_pronto;
    logic             w_char_ok;

    pa_estado_t       r_pa_estado;
    pa_estado_t       w_pa_prox;
    pa_estado_t       w_pa_seguinte;
    logic             w_aceita;
    logic             w_aceito;
    logic             w_rejeito;
    logic [11:0]      r_sombra_a;
    logic [11:0]      r_sombra_d;
    logic [11:0]      r_angulo;
    logic [11:0]      r_distancia;
    logic             r_pronto;
    logic             r_erro;

    assign w_rx       = r_sync2;
    assign w_cnt_fim  = (r_cnt == CNT_FIM);
    assign w_cnt_meio = (r_cnt == CNT_MEIO);
    assign w_char_ok  = paridade_impar(r_dados, r_par) && w_rx;

    // Two-stage synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= entrada_serial;
            r_sync2 <= r_sync1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_estado <= OCIOSO;
        end else begin
            r_rx_estado <= w_rx_prox;
        end
    end

    // Receiver next state; the stop sample returns straight to idle.
    always_comb begin
        w_rx_prox     = r_rx_estado;
        w_char_pronto = 1'b0;
        case (r_rx_estado)
            OCIOSO: begin
                if (!w_rx) w_rx_prox = INICIO;
                else       w_rx_prox = OCIOSO;
            end
            INICIO: begin
                if (w_cnt_meio) begin
                    if (w_rx) w_rx_prox = OCIOSO;
                    else      w_rx_prox = DADOS;
                end else begin
                    w_rx_prox = INICIO;
                end
            end
            DADOS: begin
                if (w_cnt_fim && (r_nbit == 3'd6)) w_rx_prox = PARIDADE;
                else                               w_rx_prox = DADOS;
            end
            PARIDADE: begin
                if (w_cnt_fim) w_rx_prox = PARADA;
                else           w_rx_prox = PARIDADE;
            end
            PARADA: begin
                if (w_cnt_fim) begin
                    w_char_pronto = 1'b1;
                    w_rx_prox     = OCIOSO;
                end else begin
                    w_rx_prox = PARADA;
                end
            end
            default: begin
                w_rx_prox = OCIOSO;
            end
        endcase
    end

    // Bit timing counter, data shift register (LSB first) and parity capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_nbit  <= 3'd0;
            r_dados <= 7'd0;
            r_par   <= 1'b0;
        end else begin
            case (r_rx_estado)
                INICIO: begin
                    r_nbit <= 3'd0;
                    if (w_cnt_meio) r_cnt <= '0;
                    else            r_cnt <= r_cnt + CNT_W'(1);
                end
                DADOS: begin
                    if (w_cnt_fim) begin
                        r_cnt   <= '0;
                        r_dados <= {w_rx, r_dados[6:1]};
                        r_nbit  <= r_nbit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PARIDADE: begin
                    if (w_cnt_fim) begin
                        r_cnt <= '0;
                        r_par <= w_rx;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PARADA: begin
                    if (w_cnt_fim) r_cnt <= '0;
                    else           r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_cnt  <= '0;
                    r_nbit <= 3'd0;
                end
            endcase
        end
    end

    // Parser state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pa_estado <= CENT_A;
        end else begin
            r_pa_estado <= w_pa_prox;
        end
    end

    // Character acceptance per parser state and next-state selection.
    always_comb begin
        w_aceita      = 1'b0;
        w_pa_seguinte = CENT_A;
        case (r_pa_estado)
            CENT_A:    begin w_aceita = eh_digito(r_dados); w_pa_seguinte = DEZ_A;     end
            DEZ_A:     begin w_aceita = eh_digito(r_dados); w_pa_seguinte = UNI_A;     end
            UNI_A:     begin w_aceita = eh_digito(r_dados); w_pa_seguinte = VIRGULA;   end
            VIRGULA:   begin w_aceita = (r_dados == 7'h2C); w_pa_seguinte = CENT_D;    end
            CENT_D:    begin w_aceita = eh_digito(r_dados); w_pa_seguinte = DEZ_D;     end
            DEZ_D:     begin w_aceita = eh_digito(r_dados); w_pa_seguinte = UNI_D;     end
            UNI_D:     begin w_aceita = eh_digito(r_dados); w_pa_seguinte = CERQUILHA; end
            CERQUILHA: begin w_aceita = (r_dados == 7'h23); w_pa_seguinte = CENT_A;    end
            default:   begin w_aceita = 1'b0;               w_pa_seguinte = CENT_A;    end
        endcase
        w_aceito  = w_char_pronto && w_char_ok && w_aceita;
        w_rejeito = w_char_pronto && !(w_char_ok && w_aceita);
        if (w_rejeito) begin
            w_pa_prox = CENT_A;
        end else if (w_aceito) begin
            w_pa_prox = w_pa_seguinte;
        end else begin
            w_pa_prox = r_pa_estado;
        end
    end

    // Shadow digit capture, frame commit on '#', and one-cycle strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sombra_a  <= 12'h000;
            r_sombra_d  <= 12'h000;
            r_angulo    <= 12'h000;
            r_distancia <= 12'h000;
            r_pronto    <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_pronto <= w_aceito && (r_pa_estado == CERQUILHA);
            r_erro   <= w_rejeito;
            if (w_rejeito) begin
                r_sombra_a <= 12'h000;
                r_sombra_d <= 12'h000;
            end else if (w_aceito) begin
                case (r_pa_estado)
                    CENT_A:    r_sombra_a[11:8] <= r_dados[3:0];
                    DEZ_A:     r_sombra_a[7:4]  <= r_dados[3:0];
                    UNI_A:     r_sombra_a[3:0]  <= r_dados[3:0];
                    CENT_D:    r_sombra_d[11:8] <= r_dados[3:0];
                    DEZ_D:     r_sombra_d[7:4]  <= r_dados[3:0];
                    UNI_D:     r_sombra_d[3:0]  <= r_dados[3:0];
                    CERQUILHA: begin
                        r_angulo    <= r_sombra_a;
                        r_distancia <= r_sombra_d;
                    end
                    default: begin
                        r_sombra_a <= r_sombra_a;
                    end
                endcase
            end else begin
                r_sombra_a <= r_sombra_a;
            end
        end
    end

    assign angulo    = r_angulo;
    assign distancia = r_distancia;
    assign pronto    = r_pronto;
    assign erro      = r_erro;
    assign db_estado = r_pa_estado;

endmodule

// File: tb/tb_receptor_sonar_ascii.sv
// Bench for receptor_sonar_ascii: drives 7O1 characters and checks every cycle
// against a frame-level model that predicts each character's outcome and timing.
module tb_receptor_sonar_ascii;

    localparam int CPB = 8;
    // Edges from driving the start bit low until pronto/erro is visible.
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        linha = 1'b1;
    logic [11:0] angulo;
    logic [11:0] distancia;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    receptor_sonar_ascii #(.CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (linha),
        .angulo         (angulo),
        .distancia      (distancia),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        bit          pr;
        bit          er;
        logic [11:0] a;
        logic [11:0] d;
        logic [3:0]  st;
    } ev_t;

    ev_t         fila[$];
    ev_t         ev_c;
    int          n_edge = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          cnt_pronto = 0;
    int          cnt_erro = 0;
    int          pe[$];
    int          last_k = 0;
    int          m_pos = 0;
    byte         m_buf[8];
    logic [11:0] m_ang = 12'h000;
    logic [11:0] m_dist = 12'h000;
    logic [11:0] e_ang = 12'h000;
    logic [11:0] e_dist = 12'h000;
    logic [3:0]  e_st = 4'd0;
    bit          e_pr;
    bit          e_er;

    always @(posedge clock) n_edge++;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", nome, got, exp, n_edge);
    endtask

    function automatic logic [3:0] dig(input byte b);
        byte v;
        v = b - 8'h30;
        return v[3:0];
    endfunction

    // Frame-level model: position in the "aaa,ddd#" template plus buffered characters.
    task automatic model_char(input byte c, input bit ok, input int k);
        ev_t ev;
        bit  acc;
        case (m_pos)
            3:       acc = (c == 8'h2C);
            7:       acc = (c == 8'h23);
            default: acc = (c >= 8'h30) && (c <= 8'h39);
        endcase
        ev.due = k + LAT;
        ev.pr  = 1'b0;
        ev.er  = 1'b0;
        if (!ok || !acc) begin
            ev.er = 1'b1;
            m_pos = 0;
        end else begin
            m_buf[m_pos] = c;
            if (m_pos == 7) begin
                ev.pr  = 1'b1;
                m_ang  = {dig(m_buf[0]), dig(m_buf[1]), dig(m_buf[2])};
                m_dist = {dig(m_buf[4]), dig(m_buf[5]), dig(m_buf[6])};
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
        ev.a  = m_ang;
        ev.d  = m_dist;
        ev.st = 4'(m_pos);
        fila.push_back(ev);
    endtask

    // Called and returns at posedge+#1.
    task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
        logic [9:0] bits;
        logic       p;
        p = ~^c;
        if (bad_par) p = ~p;
        bits   = {~bad_stop, p, c, 1'b0};
        last_k = n_edge;
        model_char({1'b0, c}, !bad_par && !bad_stop, n_edge);
        for (int j = 0; j < 10; j++) begin
            linha = bits[j];
            repeat (CPB) @(posedge clock);
            #1;
        end
        linha = 1'b1;
    endtask

    task automatic send_str(input string s, input int bad);
        byte b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_char(b[6:0], i == bad, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        linha = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Per-cycle comparison of all outputs against the model's scheduled outcomes.
    always @(negedge clock) begin
        if (!reset) begin
            e_ang = 12'h000; e_dist = 12'h000; e_st = 4'd0; e_pr = 1'b0; e_er = 1'b0;
        end else begin
            e_pr = 1'b0;
            e_er = 1'b0;
            if (fila.size() > 0 && fila[0].due < n_edge) begin
                chk("evento_perdido", fila[0].due, n_edge);
                void'(fila.pop_front());
            end
            if (fila.size() > 0 && fila[0].due == n_edge) begin
                ev_c   = fila.pop_front();
                e_pr   = ev_c.pr;
                e_er   = ev_c.er;
                e_ang  = ev_c.a;
                e_dist = ev_c.d;
                e_st   = ev_c.st;
            end
        end
        chk("pronto", 32'(pronto), 32'(e_pr));
        chk("erro", 32'(erro), 32'(e_er));
        chk("angulo", 32'(angulo), 32'(e_ang));
        chk("distancia", 32'(distancia), 32'(e_dist));
        chk("db_estado", 32'(db_estado), 32'(e_st));
        if (reset && pronto) begin
            cnt_pronto++;
            pe.push_back(n_edge);
        end
        if (reset && erro) cnt_erro++;
    end

    initial begin
        int p0, e0, b0, gap, mode, idx;
        byte fr[8];

        repeat (3) @(posedge clock);
        #1;
        chk("reset_angulo", 32'(angulo), 32'h000);
        chk("reset_distancia", 32'(distancia), 32'h000);
        chk("reset_estado", 32'(db_estado), 32'd0);
        reset = 1'b1;
        idle(5);

        // Valid frame
        p0 = cnt_pronto; e0 = cnt_erro;
        send_str("090,125#", -1);
        idle(5);
        chk("v_npronto", cnt_pronto - p0, 1);
        chk("v_nerro", cnt_erro - e0, 0);
        chk("v_angulo", 32'(angulo), 32'h090);
        chk("v_distancia", 32'(distancia), 32'h125);
        chk("v_latencia", pe[pe.size() - 1] - last_k, 79);

        // Parity error on '4'
        p0 = cnt_pronto; e0 = cnt_erro;
        send_str("045,030#", 1);
        idle(5);
        chk("par_erro", 32'(cnt_erro - e0 >= 1), 32'd1);
        chk("par_npronto", cnt_pronto - p0, 0);
        chk("par_angulo", 32'(angulo), 32'h090);
        send_str("180,007#", -1);
        idle(5);
        chk("par2_angulo", 32'(angulo), 32'h180);
        chk("par2_distancia", 32'(distancia), 32'h007);

        // Format errors
        p0 = cnt_pronto;
        send_str("09A,125#", -1);
        send_str("12,345#", -1);
        idle(5);
        chk("fmt_npronto", cnt_pronto - p0, 0);
        chk("fmt_estado", 32'(db_estado), 32'd0);
        send_str("000,400#", -1);
        idle(5);
        chk("fmt2_angulo", 32'(angulo), 32'h000);
        chk("fmt2_distancia", 32'(distancia), 32'h400);

        // Low glitch on idle line
        e0 = cnt_erro;
        linha = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        idle(20);
        chk("glitch_nerro", cnt_erro - e0, 0);
        send_str("077,321#", -1);
        idle(5);
        chk("glitch_angulo", 32'(angulo), 32'h077);
        chk("glitch_distancia", 32'(distancia), 32'h321);

        // Reset mid-frame
        send_str("12", -1);
        idle(2);
        reset = 1'b0;
        fila.delete();
        m_pos = 0; m_ang = 12'h000; m_dist = 12'h000;
        #1;
        chk("rst_angulo", 32'(angulo), 32'h000);
        chk("rst_distancia", 32'(distancia), 32'h000);
        idle(3);
        reset = 1'b1;
        idle(3);
        send_str("150,099#", -1);
        idle(5);
        chk("rst2_angulo", 32'(angulo), 32'h150);
        chk("rst2_distancia", 32'(distancia), 32'h099);

        // Back-to-back frames
        b0 = pe.size();
        send_str("033,044#055,066#", -1);
        idle(5);
        chk("b2b_npronto", pe.size() - b0, 2);
        if (pe.size() - b0 == 2) chk("b2b_intervalo", pe[b0 + 1] - pe[b0], 640);
        chk("b2b_angulo", 32'(angulo), 32'h055);

        // Framing error (stop = 0)
        e0 = cnt_erro;
        send_char(7'h31, 1'b0, 1'b1);
        idle(30);
        chk("stop_nerro", cnt_erro - e0, 1);
        send_str("201,302#", -1);
        idle(5);
        chk("stop2_distancia", 32'(distancia), 32'h302);

        // Randomized frames with occasional corruption
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 8; i++) fr[i] = 8'h30 + 8'($urandom_range(0, 9));
            fr[3] = 8'h2C;
            fr[7] = 8'h23;
            mode = $urandom_range(0, 5);
            idx  = $urandom_range(0, 7);
            if (mode == 1) fr[idx] = 8'($urandom_range(32, 126));
            for (int i = 0; i < 8; i++) send_char(fr[i][6:0], (mode == 0) && (i == idx), 1'b0);
            gap = $urandom_range(0, 20);
            if (gap > 0) idle(gap);
        end

        idle(100);
        chk("fila_vazia", fila.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/receptor_sonar_ascii.md
# receptor_sonar_ascii

Receiving end of the sonar's ASCII serial link: deserializes a 7O1 asynchronous stream and parses frames of the form "aaa,ddd#". Here aaa is the servo angle and ddd the distance, each as three ASCII decimal digits. Each valid frame produces packed BCD angle and distance words and a one-cycle `pronto` strobe. It sits on the host/FPGA side opposite the sonar transmitter, so reported measurements can be looped back, displayed or checked in hardware.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200 baud); must be ≥ 4.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `entrada_serial`  in  1  asynchronous serial line; idle high.
- `angulo`  out  12  last valid angle, BCD {centena, dezena, unidade}.
- `distancia`  out  12  last valid distance, BCD {centena, dezena, unidade}.
- `pronto`  out  1  one-cycle pulse: new frame loaded into `angulo`/`distancia`.
- `erro`  out  1  one-cycle pulse: character rejected (parity, stop bit or format).
- `db_estado`  out  4  current parser state code (debug).

## Operation
- **Input synchronizer:** `entrada_serial` passes through two flip-flops before any use. The synchronizer resets to 1.
- **Character format:** start bit (0), then d0..d6 LSB first, then parity, then stop bit (1). Parity is odd: the total count of ones in d0..d6 plus the parity bit must be odd.
- **Bit-level FSM (receiver) states:**
  - OCIOSO: wait for synced line = 0.
  - INICIO: wait CLKS_PER_BIT/2 cycles, then re-sample. If the line is 1, treat it as a false start and return to OCIOSO; otherwise go to DADOS.
  - DADOS: sample the line every CLKS_PER_BIT cycles, 7 samples shifted into a 7-bit register (d0..d6).
  - PARIDADE: take one sample after CLKS_PER_BIT cycles.
  - PARADA: take one sample after CLKS_PER_BIT cycles, then return directly to OCIOSO. There is no wait for the end of the stop bit.
- **Character result:** on the stop sample, the character is *ok* if parity is odd and stop = 1. Otherwise it is *bad*.
- **Frame parser states** (db_estado value in parentheses):
  - CENT_A (0), DEZ_A (1), UNI_A (2), VIRGULA (3), CENT_D (4), DEZ_D (5), UNI_D (6), CERQUILHA (7).
- **Parser acceptance:**
  - Digit states accept 0x30–0x39 and store the low nibble into the matching BCD field of a shadow register.
  - VIRGULA accepts only 0x2C.
  - CERQUILHA accepts only 0x23.
  - An accepted character advances to the next state.
- **Frame completion:** an accepted '#' copies the shadow angle and distance into `angulo`/`distancia`, pulses `pronto`, and returns to CENT_A.
- **Rejection:** a bad character, or an ok character not accepted in the current state, pulses `erro` and returns to CENT_A. The shadow register is discarded and the outputs hold their previous values. There is no other resynchronization mechanism.
- **No overlap:** `pronto` and `erro` are never high in the same cycle.

## Timing
- **Reset (reset = 0):**
  - `angulo`, `distancia` = 0x000; `pronto`, `erro` = 0; `db_estado` = 0.
  - Both FSMs go to OCIOSO/CENT_A; bit counters and shadow registers are cleared.
  - Reset asserted mid-character or mid-frame abandons it with no `erro` pulse.
- **Start-edge latency:** the start-edge detection sees the line two cycles after it falls, because of the synchronizer.
- **Sample instants** (relative to the cycle the synced line is first seen low, cycle 0):
  - start re-check at CLKS_PER_BIT/2;
  - d_k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - parity at CLKS_PER_BIT/2 + 8·CLKS_PER_BIT;
  - stop at CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (cycle S).
- **Output update:** `pronto` or `erro` goes high on the edge following cycle S, for exactly one clock. `angulo`/`distancia` change on that same edge.
- **Back-to-back characters:** the receiver is back in OCIOSO at S+1. A start bit beginning immediately after a full-length stop bit is caught.
- **Low glitch:** a low pulse shorter than CLKS_PER_BIT/2 cycles is rejected at the INICIO re-check, with no `erro`.
- **Framing error:** stop = 0 is counted as a bad character. The receiver then waits in OCIOSO for the line to be low again. A still-low line is treated as a new start.

## Test plan
(Use CLKS_PER_BIT = 8.)
- **Valid frame:** send "090,125#" with correct parity → exactly one `pronto` pulse, one cycle after the '#' stop sample; `angulo` = 0x090, `distancia` = 0x125; `erro` never high.
- **Parity error:** send "045,030#" with bad parity on '4' → one `erro` pulse at that character's stop sample; the remaining characters may produce further `erro` pulses; `angulo`/`distancia` keep their prior values. Then send "180,007#" → `pronto`, `angulo` = 0x180, `distancia` = 0x007.
- **Format errors:**
  - "09A,..." → `erro` on 'A'.
  - "12,345#" → `erro` on ','; then '3','4','5' are accepted into CENT_A..UNI_A and '#' gives `erro` at VIRGULA; no `pronto`.
  - A following "000,400#" → `pronto`, `distancia` = 0x400.
- **Line glitch:** a 3-cycle low pulse on the idle line → no state change, no `erro`. Then a valid frame → correct `pronto`.
- **Reset mid-frame:** drive reset low after "12" of "120,200#" → outputs 0x000/0x000 immediately. Release reset, send "150,099#" → `angulo` = 0x150, `distancia` = 0x099.
- **Back-to-back frames:** send two frames with single stop bits and no idle gap → two `pronto` pulses, exactly 8·10·CLKS_PER_BIT cycles apart, each with correct values.
